// File: rtl/router_fsm_if.sv
// router_fsm_if: handshake bundle between the router datapath and the router control FSM
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       drop_pkt;
  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, drop_pkt
  );
  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, drop_pkt
  );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: 1x3 router control FSM; define ROUTER_FSM_TIMEOUT_EN to drop packets stuck in WAIT_TILL_EMPTY
module router_fsm #(
  parameter int WAIT_TIMEOUT = 30,
  parameter int TMR_W        = 6
) (
  input logic        clk,
  input logic        rst,
  router_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
    LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  } state_e;
  if (2**TMR_W <= WAIT_TIMEOUT) begin : g_tmr_w_too_small
    $error("router_fsm: TMR_W too narrow for WAIT_TIMEOUT");
  end
  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] empty_v, srst_v;
  logic       sel_empty, sel_srst, hdr_ok, timeout;
  assign empty_v   = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_v    = {1'b0, bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0};
  assign sel_empty = empty_v[addr_q];
  assign sel_srst  = srst_v[addr_q];
  assign hdr_ok    = bus.pkt_valid && bus.data_in != 2'd3;
`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q;
  logic             drop_q;
  assign timeout      = state_q == WAIT_TILL_EMPTY && tmr_q == TMR_W'(WAIT_TIMEOUT - 1);
  assign bus.drop_pkt = drop_q;
  // timer runs only while waiting, so it is already zero on every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      tmr_q  <= state_q == WAIT_TILL_EMPTY ? tmr_q + 1'b1 : '0;
      drop_q <= timeout && !sel_empty && !sel_srst;
    end
  end
`else
  assign timeout      = 1'b0;
  assign bus.drop_pkt = 1'b0;
`endif
  // state and latched destination port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end
  // next state; a soft reset of the addressed port overrides everything but rst
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        addr_d  = hdr_ok ? bus.data_in : addr_q;
        state_d = !hdr_ok ? DECODE_ADDRESS : empty_v[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA:          state_d = bus.fifo_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    state_d = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    state_d = bus.parity_done ? DECODE_ADDRESS : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    state_d = sel_empty ? LOAD_FIRST_DATA : timeout ? DECODE_ADDRESS : WAIT_TILL_EMPTY;
      default:            state_d = DECODE_ADDRESS;
    endcase
    if (state_q != DECODE_ADDRESS && sel_srst) state_d = DECODE_ADDRESS;
  end
  assign bus.detect_add    = state_q == DECODE_ADDRESS;
  assign bus.lfd_state     = state_q == LOAD_FIRST_DATA;
  assign bus.ld_state      = state_q == LOAD_DATA;
  assign bus.laf_state     = state_q == LOAD_AFTER_FULL;
  assign bus.full_state    = state_q == FIFO_FULL_STATE;
  assign bus.rst_int_reg   = state_q == CHECK_PARITY_ERROR;
  assign bus.busy          = state_q != DECODE_ADDRESS && state_q != LOAD_DATA;
  assign bus.write_enb_reg = state_q == LOAD_DATA || state_q == LOAD_PARITY || state_q == LOAD_AFTER_FULL;
endmodule
